mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  Back end of the MIPS pipeline, directly downstream of the ALU and ID/EX buffer.
//  Registers ALU results into an EX/MEM buffer, performs lw/sw against an internal data memory,
//  then registers a MEM/WB buffer that drives the register bank write port.
//  Replaces the direct ALU->BancoRegistros WriteData path.
// PARAMETERS
//  DEPTH   256  data memory size in 32-bit words (power of 2)
//  ADDR_W  8    word-address width, = log2(DEPTH)
// PORTS
//  clk             in   1   rising-edge clock
//  rst             in   1   synchronous, active-high reset
//  stall           in   1   hold both pipeline buffers; no memory write
//  ex_valid        in   1   EX-stage instruction valid
//  ex_alu_result   in   32  ALU output; byte address for lw/sw
//  ex_store_data   in   32  ReadData2 carried through for sw
//  ex_wr_reg       in   5   destination register
//  ex_reg_write    in   1   instruction writes the register bank
//  ex_mem_read     in   1   lw
//  ex_mem_write    in   1   sw
//  ex_mem_to_reg   in   1   1 = writeback loaded word, 0 = ALU result
//  mem_reg_write   out  1   EX/MEM reg_write & valid (forwarding tap)
//  mem_wr_reg      out  5   EX/MEM destination register (forwarding tap)
//  mem_alu_result  out  32  EX/MEM ALU result (forwarding tap)
//  wb_reg_write    out  1   register bank Regwrite
//  wb_reg          out  5   register bank WriteReg
//  wb_data         out  32  register bank WriteData
//  misalign_err    out  1   one-cycle pulse: MEM access with address[1:0]!=0
// BEHAVIOUR
//  - Reset: all outputs 0, both valid bits 0, EX/MEM and MEM/WB fields 0. Memory contents are not reset.
//  - Latency: EX inputs sampled at edge N -> EX/MEM at N -> MEM/WB at N+1.
//    wb_* valid after edge N+1 (2 cycles).
//  - stall=1: both buffers hold, no store, no misalign_err pulse. Inputs are ignored that cycle.
//  - Word address = mem_alu_result[ADDR_W+1:2]. Upper bits are ignored, so addresses wrap modulo DEPTH words.
//  - Store: at the edge ending the MEM cycle, write mem[addr] <= store_data when
//    valid & mem_write & ~stall & ~rst & aligned.
//  - Load: asynchronous read of mem[addr] in MEM.
//    A load in the cycle after a store to the same address returns the new data.
//  - Writeback select: wb_data = mem_to_reg ? load word : alu_result, captured at the MEM/WB edge.
//  - wb_reg_write = MEM/WB valid & reg_write & (wb_reg != 0). $zero is never written.
//    mem_reg_write is also forced 0 for register 0.
//  - Both mem_read and mem_write set: the store executes; mem_read is ignored; writeback uses alu_result.
//  - Misaligned lw/sw (address[1:0]!=0):
//    - no memory write;
//    - reg_write suppressed in MEM/WB;
//    - misalign_err=1 for exactly the cycle after the MEM edge.
//  - Reset mid-operation: rst has priority over stall.
//    A store held in EX/MEM at the reset edge is dropped. In-flight writebacks are discarded.
//  - Bubble (ex_valid=0): propagates as valid=0. No store, no writeback, no error.
// CONFIGURATION
//  MEM_STAT_EN defined:
//   - adds outputs load_count[15:0] and store_count[15:0];
//   - each increments on every completed aligned, non-stalled lw / sw;
//   - both saturate at 16'hFFFF and clear on rst.
//  MEM_STAT_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1. rst 2 cycles -> wb_reg_write=0, wb_data=0, mem_reg_write=0, misalign_err=0.
//  2. ALU op: valid, alu_result=0x1234, wr_reg=8, reg_write, mem_to_reg=0 ->
//     two edges later wb_reg_write=1, wb_reg=8, wb_data=0x1234.
//  3. sw addr 0x10 data 0xDEADBEEF, next cycle lw addr 0x10 to r9 ->
//     wb_data=0xDEADBEEF, wb_reg=9; lw addr 0x410 (DEPTH=256) also returns 0xDEADBEEF (wrap).
//  4. lw to r0 -> wb_reg_write=0. sw addr 0x13 -> no write (later lw 0x10 unchanged),
//     misalign_err pulses 1 cycle.
//  5. stall=1 for 3 cycles with a sw in EX/MEM -> outputs frozen, single write after release;
//     with MEM_STAT_EN, store_count +1.
//  6. sw in EX/MEM when rst asserts -> memory unchanged, all outputs 0 next cycle.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB back end: EX/MEM buffer, word-addressed data memory (lw/sw), MEM/WB buffer to the register bank.
// Optional MEM_STAT_EN adds saturating load_count/store_count outputs.
module mem_wb_stage #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_wr_reg,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        ex_mem_to_reg,
  output logic        mem_reg_write,
  output logic [4:0]  mem_wr_reg,
  output logic [31:0] mem_alu_result,
  output logic        wb_reg_write,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        misalign_err
`ifdef MEM_STAT_EN
  , output logic [15:0] load_count
  , output logic [15:0] store_count
`endif
);

  // EX/MEM buffer
  logic        r_em_valid;
  logic [31:0] r_em_alu;
  logic [31:0] r_em_store;
  logic [4:0]  r_em_wr_reg;
  logic        r_em_reg_write;
  logic        r_em_mem_read;
  logic        r_em_mem_write;
  logic        r_em_mem_to_reg;

  // MEM/WB buffer
  logic        r_wb_reg_write;
  logic [4:0]  r_wb_reg;
  logic [31:0] r_wb_data;
  logic        r_misalign;

  logic [31:0] r_mem [DEPTH];

  logic [ADDR_W-1:0] w_addr;
  logic              w_misalign;
  logic              w_store;
  logic              w_load;
  logic [31:0]       w_load_word;
  logic [31:0]       w_wb_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_em_valid      <= 1'b0;
      r_em_alu        <= '0;
      r_em_store      <= '0;
      r_em_wr_reg     <= '0;
      r_em_reg_write  <= 1'b0;
      r_em_mem_read   <= 1'b0;
      r_em_mem_write  <= 1'b0;
      r_em_mem_to_reg <= 1'b0;
    end else if (!stall) begin
      r_em_valid      <= ex_valid;
      r_em_alu        <= ex_alu_result;
      r_em_store      <= ex_store_data;
      r_em_wr_reg     <= ex_wr_reg;
      r_em_reg_write  <= ex_reg_write;
      r_em_mem_read   <= ex_mem_read;
      r_em_mem_write  <= ex_mem_write;
      r_em_mem_to_reg <= ex_mem_to_reg;
    end
  end

  // Upper address bits are dropped, so accesses wrap modulo DEPTH words.
  assign w_addr      = r_em_alu[ADDR_W+1:2];
  assign w_misalign  = r_em_valid & (r_em_mem_read | r_em_mem_write) & (r_em_alu[1:0] != 2'b00);
  assign w_store     = r_em_valid & r_em_mem_write & ~w_misalign;
  assign w_load      = r_em_valid & r_em_mem_read & ~r_em_mem_write & ~w_misalign;
  assign w_load_word = r_mem[w_addr];
  // A combined read+write executes as a store and writes back the ALU result.
  assign w_wb_sel    = (r_em_mem_to_reg & r_em_mem_read & ~r_em_mem_write) ? w_load_word : r_em_alu;

  always_ff @(posedge clk) begin
    if (!rst && !stall && w_store)
      r_mem[w_addr] <= r_em_store;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_reg_write <= 1'b0;
      r_wb_reg       <= '0;
      r_wb_data      <= '0;
      r_misalign     <= 1'b0;
    end else if (!stall) begin
      r_wb_reg_write <= r_em_valid & r_em_reg_write & ~w_misalign & (r_em_wr_reg != 5'd0);
      r_wb_reg       <= r_em_wr_reg;
      r_wb_data      <= w_wb_sel;
      r_misalign     <= w_misalign;
    end else begin
      r_misalign     <= 1'b0;
    end
  end

`ifdef MEM_STAT_EN
  logic [15:0] r_load_cnt;
  logic [15:0] r_store_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_load_cnt  <= '0;
      r_store_cnt <= '0;
    end else if (!stall) begin
      if (w_load && r_load_cnt != 16'hFFFF)
        r_load_cnt <= r_load_cnt + 16'd1;
      if (w_store && r_store_cnt != 16'hFFFF)
        r_store_cnt <= r_store_cnt + 16'd1;
    end
  end

  assign load_count  = r_load_cnt;
  assign store_count = r_store_cnt;
`endif

  // Forwarding taps never advertise a write to $zero.
  assign mem_reg_write  = r_em_valid & r_em_reg_write & (r_em_wr_reg != 5'd0);
  assign mem_wr_reg     = r_em_wr_reg;
  assign mem_alu_result = r_em_alu;
  assign wb_reg_write   = r_wb_reg_write;
  assign wb_reg         = r_wb_reg;
  assign wb_data        = r_wb_data;
  assign misalign_err   = r_misalign;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with a scoreboard of expected EX/MEM and MEM/WB results.
module tb_mem_wb_stage;
  logic        clk = 1'b0;
  logic        rst, stall, ex_valid;
  logic [31:0] ex_alu_result, ex_store_data;
  logic [4:0]  ex_wr_reg;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic        mem_reg_write, wb_reg_write, misalign_err;
  logic [4:0]  mem_wr_reg, wb_reg;
  logic [31:0] mem_alu_result, wb_data;
`ifdef MEM_STAT_EN
  logic [15:0] load_count, store_count;
`endif

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_wr_reg(ex_wr_reg), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg),
    .mem_reg_write(mem_reg_write), .mem_wr_reg(mem_wr_reg),
    .mem_alu_result(mem_alu_result), .wb_reg_write(wb_reg_write),
    .wb_reg(wb_reg), .wb_data(wb_data), .misalign_err(misalign_err)
`ifdef MEM_STAT_EN
    , .load_count(load_count), .store_count(store_count)
`endif
  );

  typedef struct {
    logic        em_rw;
    logic [4:0]  em_reg;
    logic [31:0] em_alu;
    logic        wb_rw;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        mis;
  } exp_t;

  exp_t        q[$];
  exp_t        zero_e;
  exp_t        last_wb;
  logic [31:0] model [256];
  logic [31:0] saved;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic mw, input logic m2r);
    ex_valid = v; ex_alu_result = alu; ex_store_data = sd; ex_wr_reg = rd;
    ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw; ex_mem_to_reg = m2r;
  endtask

  task automatic chk_wb(input string tag, input exp_t f);
    chk({tag, ".wb_reg_write"}, {31'd0, wb_reg_write}, {31'd0, f.wb_rw});
    chk({tag, ".wb_reg"}, {27'd0, wb_reg}, {27'd0, f.wb_reg});
    chk({tag, ".wb_data"}, wb_data, f.wb_data);
    chk({tag, ".misalign_err"}, {31'd0, misalign_err}, {31'd0, f.mis});
  endtask

  task automatic chk_em(input string tag, input exp_t e);
    chk({tag, ".mem_reg_write"}, {31'd0, mem_reg_write}, {31'd0, e.em_rw});
    chk({tag, ".mem_wr_reg"}, {27'd0, mem_wr_reg}, {27'd0, e.em_reg});
    chk({tag, ".mem_alu_result"}, mem_alu_result, e.em_alu);
  endtask

  // One non-stalled cycle: predict, drive, clock, then compare both buffers.
  task automatic issue(input string tag, input logic v, input logic [31:0] alu, input logic [31:0] sd,
                       input logic [4:0] rd, input logic rw, input logic mr, input logic mw, input logic m2r);
    exp_t e;
    exp_t f;
    logic al;
    logic [7:0] a;
    al        = (alu[1:0] == 2'b00);
    a         = alu[9:2];
    e.em_rw   = v & rw & (rd != 5'd0);
    e.em_reg  = rd;
    e.em_alu  = alu;
    e.mis     = v & (mr | mw) & ~al;
    e.wb_rw   = v & rw & (rd != 5'd0) & ~e.mis;
    e.wb_reg  = rd;
    e.wb_data = (m2r & mr & ~mw) ? model[a] : alu;
    if (v && mw && al) model[a] = sd;
    q.push_back(e);
    stall = 1'b0;
    drive(v, alu, sd, rd, rw, mr, mw, m2r);
    @(posedge clk);
    @(negedge clk);
    chk_em(tag, e);
    f = q.pop_front();
    chk_wb(tag, f);
    last_wb = f;
  endtask

  task automatic stall_cycle(input string tag);
    stall = 1'b1;
    drive(1'b1, 32'h40, 32'h0BAD0BAD, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk_em(tag, q[$]);
    chk({tag, ".wb_reg_write"}, {31'd0, wb_reg_write}, {31'd0, last_wb.wb_rw});
    chk({tag, ".wb_reg"}, {27'd0, wb_reg}, {27'd0, last_wb.wb_reg});
    chk({tag, ".wb_data"}, wb_data, last_wb.wb_data);
    chk({tag, ".misalign_err"}, {31'd0, misalign_err}, 32'd0);
    stall = 1'b0;
  endtask

  task automatic do_reset(input string tag, input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    chk_em(tag, zero_e);
    chk_wb(tag, zero_e);
`ifdef MEM_STAT_EN
    chk({tag, ".store_count"}, {16'd0, store_count}, 32'd0);
    chk({tag, ".load_count"}, {16'd0, load_count}, 32'd0);
`endif
    rst = 1'b0;
    q.delete();
    q.push_back(zero_e);
    last_wb = zero_e;
  endtask

  initial begin
    zero_e = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0};
    rst = 1'b1;
    stall = 1'b0;
    drive(1'b1, 32'h10, 32'hFFFF_FFFF, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    do_reset("reset", 2);

    issue("alu",        1'b1, 32'h1234, 32'h0, 5'd8,  1'b1, 1'b0, 1'b0, 1'b0);
    issue("sw10",       1'b1, 32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    issue("lw10_r9",    1'b1, 32'h10, 32'h0, 5'd9,  1'b1, 1'b1, 1'b0, 1'b1);
    issue("lw410_r10",  1'b1, 32'h410, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1);
    issue("lw_r0",      1'b1, 32'h10, 32'h0, 5'd0,  1'b1, 1'b1, 1'b0, 1'b1);
    issue("sw13_mis",   1'b1, 32'h13, 32'h11111111, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    issue("lw10_r11",   1'b1, 32'h10, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, 1'b1);
    issue("rdwr20",     1'b1, 32'h20, 32'hCAFEF00D, 5'd12, 1'b1, 1'b1, 1'b1, 1'b1);
    issue("lw20_r13",   1'b1, 32'h20, 32'h0, 5'd13, 1'b1, 1'b1, 1'b0, 1'b1);
    issue("bubble",     1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    issue("sw40",       1'b1, 32'h40, 32'hA5A5A5A5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    stall_cycle("stall1");
    stall_cycle("stall2");
    stall_cycle("stall3");
    issue("lw40_r14",   1'b1, 32'h40, 32'h0, 5'd14, 1'b1, 1'b1, 1'b0, 1'b1);
    issue("drain1",     1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue("drain2",     1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef MEM_STAT_EN
    chk("stat.store_count", {16'd0, store_count}, 32'd3);
    chk("stat.load_count",  {16'd0, load_count},  32'd6);
`endif

    saved = model[4];
    issue("sw10_rst",   1'b1, 32'h10, 32'h55555555, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    model[4] = saved;
    do_reset("rst_mid", 1);
    issue("lw10_r15",   1'b1, 32'h10, 32'h0, 5'd15, 1'b1, 1'b1, 1'b0, 1'b1);
    issue("drain3",     1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
